reg_write_arbiter: RTL and testbench

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_arb_pkg.sv | 22 ++
 rtl/rr_pick.sv | 28 ++
 rtl/reg_write_arbiter.sv | 101 ++++++++++
 tb/tb_reg_write_arbiter.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// Shared definitions for the register write arbiter: requester count,
// default lock length, FSM encoding and a one-hot to index helper.
package reg_arb_pkg;

    localparam int NUM_REQ      = 4;
    localparam int LOCK_MAX_DEF = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [1:0] oh_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches upward from last+1 with wrap,
// returns a one-hot winner and a valid flag.
module rr_pick
    import reg_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         last,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);

    logic [1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 2'd0;
        // i = 4 wraps back to last itself, so the previous winner is checked last
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = last + 2'(i);
            if (!valid && req[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter in front of a shared N-bit register.
// Optional grant locking is enabled with macro REG_ARB_LOCK_EN.
//
//   state | meaning
//   IDLE  | no write issued this cycle, gnt = 0, load = 0
//   GRANT | one requester's write issued, gnt one-hot, load = 1
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int N        = 8,
    parameter int LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*N-1:0] wdata,
    output logic [NUM_REQ-1:0]   gnt,
    output logic                 load,
    output logic [N-1:0]         d,
    output logic                 busy
);

    if (LOCK_MAX < 1) begin : g_bad_lock_max
        $error("LOCK_MAX must be at least 1");
    end

    state_t             state, state_nxt;
    logic [1:0]         last_q, last_nxt;
    logic [NUM_REQ-1:0] pick, sel, gnt_nxt;
    logic               pick_valid, sel_valid, load_nxt;
    logic [1:0]         sel_idx;
    logic [N-1:0]       d_nxt;

    rr_pick u_rr_pick (
        .req    (req),
        .last   (last_q),
        .winner (pick),
        .valid  (pick_valid)
    );

`ifdef REG_ARB_LOCK_EN
    localparam int CW = $clog2(LOCK_MAX + 1);
    logic [CW-1:0] lock_q, lock_nxt;
    logic          hold;

    // Once the counter saturates the normal search runs; it visits the holder
    // last, so the holder only wins again when nobody else is requesting.
    assign hold = (state == GRANT) && |(req & gnt) && (lock_q < CW'(LOCK_MAX));
`endif

    always_comb begin
        sel       = pick;
        sel_valid = pick_valid;
`ifdef REG_ARB_LOCK_EN
        lock_nxt  = pick_valid ? CW'(1) : '0;
        if (hold) begin
            sel       = gnt;
            sel_valid = 1'b1;
            lock_nxt  = lock_q + CW'(1);
        end
`endif
        sel_idx   = oh_to_idx(sel);
        state_nxt = IDLE;
        gnt_nxt   = '0;
        load_nxt  = 1'b0;
        d_nxt     = d;
        last_nxt  = last_q;
        if (sel_valid) begin
            state_nxt = GRANT;
            gnt_nxt   = sel;
            load_nxt  = 1'b1;
            d_nxt     = wdata[int'(sel_idx)*N +: N];
            last_nxt  = sel_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= IDLE;
            gnt    <= '0;
            load   <= 1'b0;
            d      <= '0;
            last_q <= 2'd3;
`ifdef REG_ARB_LOCK_EN
            lock_q <= '0;
`endif
        end else begin
            state  <= state_nxt;
            gnt    <= gnt_nxt;
            load   <= load_nxt;
            d      <= d_nxt;
            last_q <= last_nxt;
`ifdef REG_ARB_LOCK_EN
            lock_q <= lock_nxt;
`endif
        end
    end

    assign busy = (state == GRANT);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: vector table plus short hand-written
// sequences for glitching requests and (when enabled) grant locking.
module tb_reg_write_arbiter;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         clr;
    logic [3:0]   req;
    logic [4*N-1:0] wdata;
    logic [3:0]   gnt;
    logic         load;
    logic [N-1:0] d;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    reg_write_arbiter #(.N(N), .LOCK_MAX(8)) dut (
        .clk   (clk),
        .clr   (clr),
        .req   (req),
        .wdata (wdata),
        .gnt   (gnt),
        .load  (load),
        .d     (d),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         clr;
        logic [3:0]   req;
        logic [4*N-1:0] wdata;
        logic [3:0]   gnt;
        logic         load;
        logic [N-1:0] d;
    } vec_t;

    vec_t vecs[$];

    localparam logic [4*N-1:0] W0 = {8'h44, 8'h33, 8'h22, 8'h11};
    localparam logic [4*N-1:0] W1 = {8'h44, 8'hA5, 8'h22, 8'h11};
    localparam logic [4*N-1:0] W2 = {8'h44, 8'h33, 8'hBB, 8'hCC};

    task automatic add(input logic c, input logic [3:0] r, input logic [4*N-1:0] w,
                       input logic [3:0] g, input logic l, input logic [N-1:0] dd);
        vec_t v;
        v.clr = c; v.req = r; v.wdata = w; v.gnt = g; v.load = l; v.d = dd;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive inputs just after an edge, then sample just after the next edge.
    task automatic step(input logic c, input logic [3:0] r, input logic [4*N-1:0] w);
        clr = c; req = r; wdata = w;
        @(posedge clk);
        #1;
        check("onehot", 32'($countones(gnt) <= 1), 32'd1);
        check("load_eq_or_gnt", 32'(load), 32'(|gnt));
        check("busy_eq_load", 32'(busy), 32'(load));
    endtask

    initial begin
        clr = 1'b1; req = '0; wdata = '0;
        // reset held two cycles with every request asserted
        add(1, 4'b1111, W0, 4'b0000, 0, 8'h00);
        add(1, 4'b1111, W0, 4'b0000, 0, 8'h00);
        add(0, 4'b1111, W0, 4'b0001, 1, 8'h11);
        add(0, 4'b0000, W0, 4'b0000, 0, 8'h11);
        // single write from requester 2
        add(0, 4'b0100, W1, 4'b0100, 1, 8'hA5);
        add(0, 4'b0000, W0, 4'b0000, 0, 8'hA5);
        // rotation after reset with 1011 held
        add(1, 4'b1011, W0, 4'b0000, 0, 8'h00);
        add(0, 4'b1011, W0, 4'b0001, 1, 8'h11);
        add(0, 4'b1011, W0, 4'b0010, 1, 8'h22);
        add(0, 4'b1011, W0, 4'b1000, 1, 8'h44);
        add(0, 4'b1011, W0, 4'b0001, 1, 8'h11);
        add(0, 4'b1011, W0, 4'b0010, 1, 8'h22);
        // reset while requester 1 is granted, priority returns to requester 0
        add(1, 4'b0011, W0, 4'b0000, 0, 8'h00);
        add(0, 4'b0011, W0, 4'b0001, 1, 8'h11);
        add(0, 4'b0000, W0, 4'b0000, 0, 8'h11);
        // requester 1 pulse, idle gap, then 0011 searches from 2 and wraps to 0
        add(0, 4'b0010, W0, 4'b0010, 1, 8'h22);
        add(0, 4'b0000, W0, 4'b0000, 0, 8'h22);
        add(0, 4'b0000, W0, 4'b0000, 0, 8'h22);
        add(0, 4'b0000, W0, 4'b0000, 0, 8'h22);
        add(0, 4'b0011, W2, 4'b0001, 1, 8'hCC);
        add(0, 4'b0011, W2, 4'b0010, 1, 8'hBB);
        add(0, 4'b0000, W2, 4'b0000, 0, 8'hBB);
        // lone requester is granted every cycle, data follows wdata
        add(0, 4'b1000, W0, 4'b1000, 1, 8'h44);
        add(0, 4'b1000, W2, 4'b1000, 1, 8'h44);
        add(0, 4'b1000, {8'h5A, 24'h0}, 4'b1000, 1, 8'h5A);
        add(0, 4'b0000, W0, 4'b0000, 0, 8'h5A);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].clr, vecs[i].req, vecs[i].wdata);
            check($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
            check($sformatf("v%0d_load", i), 32'(load), 32'(vecs[i].load));
            check($sformatf("v%0d_d", i), 32'(d), 32'(vecs[i].d));
        end

        // request that drops before the sampling edge is never granted
        clr = 1'b0; req = 4'b0100; wdata = W1;
        #3 req = 4'b0000;
        @(posedge clk);
        #1;
        check("glitch_gnt", 32'(gnt), 32'd0);
        check("glitch_load", 32'(load), 32'd0);
        check("glitch_d_hold", 32'(d), 32'h5A);

`ifdef REG_ARB_LOCK_EN
        step(1, 4'b0000, W0);
        for (int k = 0; k < 17; k++) begin
            step(0, 4'b0011, W0);
            check($sformatf("lock_c%0d_gnt", k), 32'(gnt),
                  (k >= 8 && k < 16) ? 32'b0010 : 32'b0001);
        end
        // holder alone past the limit keeps the grant
        for (int k = 0; k < 10; k++) begin
            step(0, 4'b0001, W0);
            check($sformatf("lock_solo%0d_gnt", k), 32'(gnt), 32'b0001);
        end
`else
        // without locking, two held requests alternate every cycle
        step(1, 4'b0000, W0);
        for (int k = 0; k < 4; k++) begin
            step(0, 4'b0011, W0);
            check($sformatf("alt%0d_gnt", k), 32'(gnt), (k % 2 == 0) ? 32'b0001 : 32'b0010);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
